// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache line fill controller: FSM encoding, block geometry
// and address field positions.
package cache_fill_ctrl_pkg;

  localparam int BLOCK_WORDS = 8;
  localparam int TAG_W       = 9;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

  localparam int OFFSET_MSB  = 3;
  localparam int OFFSET_LSB  = 0;
  localparam int WORD_LSB    = 1;
  localparam int BLK_LSB     = OFFSET_MSB + 1;
  localparam int TAG_MSB     = 15;
  localparam int TAG_LSB     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_TAG  = 2'd3
  } fill_state_e;

endpackage

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Saturating beat counter (stops at BLOCK_WORDS) with a 3-bit wrapping word index
// that can be loaded with an arbitrary starting word.
module fill_counter
  import cache_fill_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign done_o = (cnt_q == CNT_W'(BLOCK_WORDS));
  assign cnt_o  = cnt_q;
  assign idx_o  = idx_q;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (load_i) begin
      cnt_d = '0;
      idx_d = start_i;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: issues 8 word reads for a missing block, writes the
// returned words and then the tag. Define FILL_CRITICAL_FIRST_EN for critical-word-first.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              mem_data_valid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              data_write,
  output logic [IDX_W-1:0]  word_sel,
  output logic              tag_write,
  output logic [TAG_W-1:0]  tag_data,
  output logic              busy,
  output logic              fill_done
);

  fill_state_e state_q, state_d;

  logic [ADDR_W-BLK_LSB-1:0] blk_q;
  logic                      cap_q;
  logic                      accept;
  logic [IDX_W-1:0]          start_idx;
  logic [CNT_W-1:0]          req_cnt, resp_cnt;
  logic [IDX_W-1:0]          req_idx, resp_idx;
  logic                      req_done, resp_done;
  logic                      req_en, resp_en;
  logic                      req_last, resp_last;
  logic                      unused_offset;

  assign accept = (state_q == ST_IDLE) && miss_detected;
  assign unused_offset = ^miss_addr[OFFSET_MSB:OFFSET_LSB];

`ifdef FILL_CRITICAL_FIRST_EN
  assign start_idx = miss_addr[OFFSET_MSB:WORD_LSB];
`else
  assign start_idx = '0;
`endif

  assign req_en    = (state_q == ST_REQ) && !req_done;
  assign req_last  = req_en && (req_cnt == CNT_W'(BLOCK_WORDS - 1));
  assign resp_en   = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && mem_data_valid && !resp_done;
  assign resp_last = resp_en && (resp_cnt == CNT_W'(BLOCK_WORDS - 1));

  fill_counter u_req_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (accept),
    .en_i   (req_en),
    .start_i(start_idx),
    .cnt_o  (req_cnt),
    .idx_o  (req_idx),
    .done_o (req_done)
  );

  fill_counter u_resp_cnt (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (accept),
    .en_i   (resp_en),
    .start_i(start_idx),
    .cnt_o  (resp_cnt),
    .idx_o  (resp_idx),
    .done_o (resp_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        blk_q <= miss_addr[ADDR_W-1:BLK_LSB];
        cap_q <= 1'b1;
      end
    end
  end

  // With zero memory latency the last response coincides with the last request,
  // so REQ may skip WAIT entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (req_last || req_done) state_d = (resp_last || resp_done) ? ST_TAG : ST_WAIT;
      ST_WAIT: if (resp_last || resp_done) state_d = ST_TAG;
      ST_TAG:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign tag_data = {cap_q, blk_q[TAG_MSB-BLK_LSB:TAG_LSB-BLK_LSB]};

  always_comb begin
    mem_en     = 1'b0;
    mem_addr   = '0;
    data_write = resp_en;
    word_sel   = resp_en ? resp_idx : '0;
    tag_write  = 1'b0;
    fill_done  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      ST_IDLE: busy = miss_detected && rst;
      ST_REQ: begin
        busy     = 1'b1;
        mem_en   = req_en;
        mem_addr = req_en ? {blk_q, req_idx, 1'b0} : '0;
      end
      ST_WAIT: busy = 1'b1;
      ST_TAG: begin
        busy      = 1'b1;
        tag_write = 1'b1;
        fill_done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed self-checking bench for cache_fill_ctrl; expected word order follows
// FILL_CRITICAL_FIRST_EN when that macro is defined for the build.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_addr;
  logic        mem_data_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        data_write;
  logic [2:0]  word_sel;
  logic        tag_write;
  logic [8:0]  tag_data;
  logic        busy;
  logic        fill_done;

  int checks = 0;
  int errors = 0;
  bit critFirst;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.ADDR_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_detected (miss_detected),
    .miss_addr     (miss_addr),
    .mem_data_valid(mem_data_valid),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .data_write    (data_write),
    .word_sel      (word_sel),
    .tag_write     (tag_write),
    .tag_data      (tag_data),
    .busy          (busy),
    .fill_done     (fill_done)
  );

  task automatic applyStimulus(input logic miss, input logic [15:0] addr, input logic valid);
    miss_detected  = miss;
    miss_addr      = addr;
    mem_data_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_mem_en"}, 16'(mem_en), 16'h0);
    checkOutput({tag, "_data_write"}, 16'(data_write), 16'h0);
    checkOutput({tag, "_tag_write"}, 16'(tag_write), 16'h0);
    checkOutput({tag, "_fill_done"}, 16'(fill_done), 16'h0);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    #1;
    checkQuiet(tag);
    checkOutput({tag, "_busy"}, 16'(busy), 16'h0);
    @(negedge clk);
  endtask

  // Cycle 0 accepts the miss; requests on 1..8, responses on 1+lat..8+lat, TAG on 9+lat.
  task automatic runFill(input string tag, input logic [15:0] addr, input int lat,
                         input bit extraValid, input bit holdMiss);
    int start;
    int tagCount;
    int busyCount;
    int tagCycle;
    bit valid;
    logic [2:0] idx;
    start     = critFirst ? int'(addr[3:1]) : 0;
    tagCount  = 0;
    busyCount = 0;
    tagCycle  = 9 + lat;
    for (int c = 0; c <= tagCycle; c++) begin
      valid = (c >= 1 + lat && c <= 8 + lat) || (extraValid && c == tagCycle);
      applyStimulus((c == 0) || holdMiss, addr, valid);
      #1;
      if (busy) busyCount++;
      if (tag_write) tagCount++;
      checkOutput($sformatf("%s_mem_en_c%0d", tag, c), 16'(mem_en), 16'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        idx = 3'((start + c - 1) % 8);
        checkOutput($sformatf("%s_mem_addr_c%0d", tag, c), mem_addr, {addr[15:4], idx, 1'b0});
      end
      checkOutput($sformatf("%s_data_write_c%0d", tag, c), 16'(data_write),
                  16'(c >= 1 + lat && c <= 8 + lat));
      if (c >= 1 + lat && c <= 8 + lat)
        checkOutput($sformatf("%s_word_sel_c%0d", tag, c), 16'(word_sel),
                    16'((start + c - 1 - lat) % 8));
      checkOutput($sformatf("%s_tag_write_c%0d", tag, c), 16'(tag_write), 16'(c == tagCycle));
      checkOutput($sformatf("%s_fill_done_c%0d", tag, c), 16'(fill_done), 16'(c == tagCycle));
      if (c == tagCycle)
        checkOutput({tag, "_tag_data"}, 16'(tag_data), 16'({1'b1, addr[15:8]}));
      @(negedge clk);
    end
    checkOutput({tag, "_tag_count"}, 16'(tagCount), 16'd1);
    checkOutput({tag, "_busy_cycles"}, 16'(busyCount), 16'(10 + lat));
  endtask

  initial begin
`ifdef FILL_CRITICAL_FIRST_EN
    critFirst = 1'b1;
`else
    critFirst = 1'b0;
`endif
    $display("[TB] start, critical-word-first=%0d", critFirst);

    // Reset: every output low even with a miss and a valid pending
    rst = 1'b0;
    applyStimulus(1'b1, 16'hA3C6, 1'b1);
    #1;
    checkQuiet("rst");
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_tag_data", 16'(tag_data), 16'h0);
    checkOutput("rst_mem_addr", mem_addr, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    idleCycle("post_rst");
    checkOutput("post_rst_tag_data", 16'(tag_data), 16'h0);

    // Spurious response in IDLE
    applyStimulus(1'b0, 16'h0000, 1'b1);
    #1;
    checkOutput("idle_valid_dw", 16'(data_write), 16'h0);
    checkOutput("idle_valid_busy", 16'(busy), 16'h0);
    @(negedge clk);

    $display("[TB] fill latency 2");
    runFill("lat2", 16'hA3C6, 2, 1'b0, 1'b0);
    idleCycle("after_lat2");
    checkOutput("after_lat2_tag_data", 16'(tag_data), 16'h1A3);

    $display("[TB] fill latency 0 with 9th valid in TAG");
    runFill("lat0", 16'hA3C6, 0, 1'b1, 1'b0);
    idleCycle("after_lat0");

    $display("[TB] reset on 5th response");
    for (int c = 0; c <= 7; c++) begin
      applyStimulus(c == 0, 16'hA3C6, c >= 3);
      #1;
      if (c == 7) begin
        checkOutput("abort_dw_before", 16'(data_write), 16'h1);
        checkOutput("abort_ws_before", 16'(word_sel), 16'(((critFirst ? 3 : 0) + 4) % 8));
        rst = 1'b0;
        #1;
        checkQuiet("abort");
        checkOutput("abort_busy", 16'(busy), 16'h0);
        checkOutput("abort_word_sel", 16'(word_sel), 16'h0);
        checkOutput("abort_mem_addr", mem_addr, 16'h0);
        checkOutput("abort_tag_data", 16'(tag_data), 16'h0);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    idleCycle("after_abort");
    runFill("restart", 16'hA3C6, 2, 1'b0, 1'b0);
    idleCycle("after_restart");

    $display("[TB] miss held high through fill_done");
    runFill("held1", 16'hA3C6, 1, 1'b0, 1'b1);
    runFill("held2", 16'h5B2E, 1, 1'b0, 1'b0);
    idleCycle("after_held");
    checkOutput("after_held_tag_data", 16'(tag_data), 16'h15B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
